// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared types and constants for the NEC infrared sender.
//   nec_state_e : frame sequencer states
//   *_U         : phase lengths in NEC units
//   FRAME_BITS  : payload length
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } nec_state_e;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int ONE_SPACE_U  = 3;
  localparam int ZERO_SPACE_U = 1;
  localparam int MARK_U       = 1;
  localparam int FRAME_BITS   = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_nec_carrier_gen.sv
// ir_carrier_gen: free-running carrier divider for the IR LED modulation.
//   clk, rst    : clock, async active-high reset
//   restart_i   : force count to 0 (asserted on the edge entering a mark)
//   en_i        : advance the count
//   carrier_o   : high while count < CARRIER_HIGH
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  input  logic en_i,
  output logic carrier_o
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt_q <= '0;
    else if (restart_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= (cnt_q == CW'(CARRIER_DIV - 1)) ? '0 : cnt_q + CW'(1);
  end

  assign carrier_o = (cnt_q < CW'(CARRIER_HIGH));

endmodule

// File: rtl/ir_nec_sender.sv
// ir_nec_sender: emits one NEC infrared frame per accepted request.
//   clk, rst : clock, async active-high reset
//   Enable   : request level, asynchronous to clk (rising edge = request)
//   Conduct  : request code, 1..4 select CMD_1..CMD_4, others ignored
//   ir_out   : carrier-modulated LED drive
//   ir_env   : mark envelope
//   busy     : frame plus trailing gap in progress
//   done     : one-cycle pulse after the gap
module ir_nec_sender
  import ir_nec_pkg::*;
#(
  parameter int         UNIT_CYC     = 28125,
  parameter int         CARRIER_DIV  = 1316,
  parameter int         CARRIER_HIGH = 439,
  parameter int         GAP_UNITS    = 72,
  parameter logic [7:0] ADDR         = 8'h00,
  parameter logic [7:0] CMD_1        = 8'h45,
  parameter logic [7:0] CMD_2        = 8'h46,
  parameter logic [7:0] CMD_3        = 8'h47,
  parameter logic [7:0] CMD_4        = 8'h44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic [2:0] Conduct,
  output logic       ir_out,
  output logic       ir_env,
  output logic       busy,
  output logic       done
);

  localparam int CYC_W  = $clog2(UNIT_CYC);
  localparam int UNIT_W = $clog2(max_int(LEAD_MARK_U, GAP_UNITS) + 1);

  // 2-flop synchronisers plus one history flop for edge detection
  logic       en_s1_q, en_s2_q, en_prev_q;
  logic [2:0] cond_s1_q, cond_s2_q;

  nec_state_e              state_q, state_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [UNIT_W-1:0]       unit_q, unit_d, unit_lim;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    env_q, env_d, busy_q, busy_d, done_q, done_d;

  logic       start, cmd_valid, unit_end, phase_end, carrier, restart;
  logic [7:0] cmd_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_prev_q <= 1'b0;
      cond_s1_q <= '0;
      cond_s2_q <= '0;
    end else begin
      en_s1_q   <= Enable;
      en_s2_q   <= en_s1_q;
      en_prev_q <= en_s2_q;
      cond_s1_q <= Conduct;
      cond_s2_q <= cond_s1_q;
    end
  end

  assign start = en_s2_q & ~en_prev_q;

  always_comb begin
    cmd_valid = 1'b1;
    cmd_byte  = CMD_1;
    case (cond_s2_q)
      3'd1:    cmd_byte = CMD_1;
      3'd2:    cmd_byte = CMD_2;
      3'd3:    cmd_byte = CMD_3;
      3'd4:    cmd_byte = CMD_4;
      default: cmd_valid = 1'b0;
    endcase
  end

  // Last unit index of the current phase; bit spaces depend on the bit
  // currently at the bottom of the shift register.
  always_comb begin
    unit_lim = '0;
    case (state_q)
      ST_LEAD_MARK:  unit_lim = UNIT_W'(LEAD_MARK_U - 1);
      ST_LEAD_SPACE: unit_lim = UNIT_W'(LEAD_SPACE_U - 1);
      ST_BIT_MARK:   unit_lim = UNIT_W'(MARK_U - 1);
      ST_BIT_SPACE:  unit_lim = shreg_q[0] ? UNIT_W'(ONE_SPACE_U - 1)
                                           : UNIT_W'(ZERO_SPACE_U - 1);
      ST_STOP_MARK:  unit_lim = UNIT_W'(MARK_U - 1);
      ST_GAP:        unit_lim = UNIT_W'(GAP_UNITS - 1);
      default:       unit_lim = '0;
    endcase
  end

  assign unit_end  = (cyc_q == CYC_W'(UNIT_CYC - 1));
  assign phase_end = unit_end && (unit_q == unit_lim);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q == ST_IDLE) begin
      if (start && cmd_valid) begin
        state_d = ST_LEAD_MARK;
        shreg_d = {~cmd_byte, cmd_byte, ~ADDR, ADDR};
        bit_d   = '0;
        cyc_d   = '0;
        unit_d  = '0;
      end
    end else begin
      if (unit_end) begin
        cyc_d  = '0;
        unit_d = phase_end ? '0 : unit_q + UNIT_W'(1);
      end else begin
        cyc_d  = cyc_q + CYC_W'(1);
      end
      if (phase_end) begin
        case (state_q)
          ST_LEAD_MARK:  state_d = ST_LEAD_SPACE;
          ST_LEAD_SPACE: state_d = ST_BIT_MARK;
          ST_BIT_MARK:   state_d = ST_BIT_SPACE;
          ST_BIT_SPACE: begin
            if (bit_q == 5'd31) begin
              state_d = ST_STOP_MARK;
            end else begin
              state_d = ST_BIT_MARK;
              bit_d   = bit_q + 5'd1;
              shreg_d = shreg_q >> 1;
            end
          end
          ST_STOP_MARK:  state_d = ST_GAP;
          default:       state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign env_d  = (state_d == ST_LEAD_MARK) || (state_d == ST_BIT_MARK) ||
                  (state_d == ST_STOP_MARK);
  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_q == ST_GAP) && phase_end;
  // No mark follows another mark directly, so any state change into a mark
  // is a mark entry.
  assign restart = env_d && (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      env_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      env_q   <= env_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HIGH(CARRIER_HIGH)
  ) u_carrier (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .en_i     (env_q),
    .carrier_o(carrier)
  );

  assign ir_out = env_q & carrier;
  assign ir_env = env_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
